// File: rtl/hex_display_scan.sv
// Time-multiplexed 4-digit hex display driver with tear-free snapshot,
// optional leading-zero blanking and a one-cycle frame pulse per snapshot.
module hex_display_scan #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic [15:0] dataIn,
    input  logic        freeze,
    input  logic        blank_lz,
    output logic [3:0]  anodes,
    output logic [6:0]  segs,
    output logic        frame
);

    localparam logic [15:0] TC_VAL = 16'(REFRESH_DIV - 1);

    logic [15:0] cnt;
    logic [1:0]  idx;
    logic [15:0] snap;
    logic        tc;
    logic        wrap;
    logic        load;
    logic        blank;
    logic [3:0]  nib;
    logic [3:0]  an_dec;
    logic [6:0]  seg_dec;

    assign tc   = (cnt == TC_VAL);
    assign wrap = tc && (idx == 2'd3);
    assign load = wrap && !freeze;

    always_ff @(posedge CLK) begin
        if (reset) begin
            cnt    <= '0;
            idx    <= '0;
            snap   <= '0;
            frame  <= 1'b0;
            anodes <= 4'hF;
            segs   <= 7'h7F;
        end else begin
            cnt   <= tc ? '0 : cnt + 16'd1;
            if (tc)
                idx <= idx + 2'd1;
            frame <= load;
            if (load)
                snap <= dataIn;
            // Outputs lag index/snapshot by one cycle
            anodes <= blank ? 4'hF  : an_dec;
            segs   <= blank ? 7'h7F : seg_dec;
        end
    end

    always_comb begin
        nib    = snap[{idx, 2'b00} +: 4];
        an_dec = ~(4'b0001 << idx);
        blank  = 1'b0;
        // Digit k blanks only if it and every more-significant nibble are zero
        case (idx)
            2'd1:    blank = blank_lz && (snap[15:4]  == 12'h000);
            2'd2:    blank = blank_lz && (snap[15:8]  == 8'h00);
            2'd3:    blank = blank_lz && (snap[15:12] == 4'h0);
            default: blank = 1'b0;
        endcase
    end

    always_comb begin
        seg_dec = 7'h7F;
        case (nib)
            4'h0: seg_dec = 7'h40;
            4'h1: seg_dec = 7'h79;
            4'h2: seg_dec = 7'h24;
            4'h3: seg_dec = 7'h30;
            4'h4: seg_dec = 7'h19;
            4'h5: seg_dec = 7'h12;
            4'h6: seg_dec = 7'h02;
            4'h7: seg_dec = 7'h78;
            4'h8: seg_dec = 7'h00;
            4'h9: seg_dec = 7'h10;
            4'hA: seg_dec = 7'h08;
            4'hB: seg_dec = 7'h03;
            4'hC: seg_dec = 7'h46;
            4'hD: seg_dec = 7'h21;
            4'hE: seg_dec = 7'h06;
            4'hF: seg_dec = 7'h0E;
            default: seg_dec = 7'h7F;
        endcase
    end

endmodule
